// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined ARM-subset control unit.
//   op_t        : instruction class held in Instr[27:26]
//   CMD_*       : data-processing cmd field values, Instr[24:21]
//   ALU_*       : ALUControl encodings (3-bit superset)
//   COND_*      : ARM condition codes
//   FLAG_*      : NZCV bit positions inside the flag register
//   ectl_t      : Execute-stage control bundle, ALU control excluded
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic       regw;
    logic       memw;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       pcs;
    logic       nowrite;
    logic [1:0] flagw;
    logic [3:0] cond;
  } ectl_t;

endpackage

// File: rtl/pipelined_controller_p_cond_check.sv
// Condition-code evaluator (combinational).
//   cond   : ARM condition field of the instruction in Execute
//   flags  : current NZCV register
//   condex : 1 when the instruction should execute; code 4'hF never executes
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags[FLAG_N];
    z  = flags[FLAG_Z];
    c  = flags[FLAG_C];
    v  = flags[FLAG_V];
    ge = (n == v);
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = ge;
      COND_LT: condex = ~ge;
      COND_GT: condex = ~z & ge;
      COND_LE: condex = z | ~ge;
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_controller_p.sv
// Control unit for the five-stage ARM-subset CPU.
// Decodes Instr[31:12] in Decode, carries control through E/M/W, resolves
// conditional execution and the NZCV register in Execute.
//   clk, reset            : clock, synchronous active-low reset
//   Instr_D               : Instr[31:12] in Decode
//   ALUFlags_E            : NZCV from the ALU for the instruction in E
//   FlushE / StallE       : hazard-unit bubble / hold controls
//   RegSrc_D, ImmSrc_D    : combinational Decode selects
//   ALUSrc_E, ALUControl_E, BranchTaken_E, MemtoReg_E : Execute controls
//   RegWrite_M, MemWrite_M                            : Memory controls
//   RegWrite_W, MemtoReg_W, PCSrc_W                   : Writeback controls
//   PCWrPending_F         : a PC write is in flight in D, E or M
//   Flags_q               : architectural NZCV
module pipelined_controller_p
  import ctrl_pkg::*;
#(
  parameter int ALUCTL_W = 2,
  parameter int EXT_ALU  = 0,
  parameter int FLAGS_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [19:0]         Instr_D,
  input  logic [FLAGS_W-1:0]  ALUFlags_E,
  input  logic                FlushE,
  input  logic                StallE,
  output logic [1:0]          RegSrc_D,
  output logic [1:0]          ImmSrc_D,
  output logic                ALUSrc_E,
  output logic [ALUCTL_W-1:0] ALUControl_E,
  output logic                BranchTaken_E,
  output logic                MemtoReg_E,
  output logic                RegWrite_M,
  output logic                MemWrite_M,
  output logic                RegWrite_W,
  output logic                MemtoReg_W,
  output logic                PCSrc_W,
  output logic                PCWrPending_F,
  output logic [FLAGS_W-1:0]  Flags_q
);

  op_t                 op;
  logic [5:0]          funct;
  logic [3:0]          cmd;
  logic [3:0]          rd;
  ectl_t               d, e;
  logic [ALUCTL_W-1:0] alu_d, alu_e;
  logic                is_dp, known, arith;
  logic                condex;
  logic                memtoreg_m, pcsrc_m, pcs_m;

  assign op    = op_t'(Instr_D[15:14]);
  assign funct = Instr_D[13:8];
  assign cmd   = funct[4:1];
  assign rd    = Instr_D[3:0];

  always_comb begin
    d        = '0;
    d.cond   = Instr_D[19:16];
    RegSrc_D = 2'b00;
    ImmSrc_D = 2'b00;
    is_dp    = 1'b0;
    case (op)
      OP_DP: begin
        d.regw   = 1'b1;
        d.alusrc = funct[5];
        is_dp    = 1'b1;
      end
      OP_MEM: begin
        d.alusrc = 1'b1;
        ImmSrc_D = 2'b01;
        if (funct[0]) begin
          d.memtoreg = 1'b1;
          d.regw     = 1'b1;
        end else begin
          d.memw   = 1'b1;
          RegSrc_D = 2'b10;
        end
      end
      OP_BR: begin
        d.branch = 1'b1;
        d.alusrc = 1'b1;
        ImmSrc_D = 2'b10;
        RegSrc_D = 2'b01;
      end
      default: ;
    endcase

    // Non-DP classes always use ADD; unrecognised DP cmds fall back to ADD
    // with the register write suppressed.
    alu_d = ALUCTL_W'(ALU_ADD);
    known = 1'b1;
    arith = 1'b0;
    if (is_dp) begin
      case (cmd)
        CMD_ADD: arith = 1'b1;
        CMD_SUB: begin alu_d = ALUCTL_W'(ALU_SUB); arith = 1'b1; end
        CMD_AND: alu_d = ALUCTL_W'(ALU_AND);
        CMD_ORR: alu_d = ALUCTL_W'(ALU_ORR);
        CMD_EOR: begin
          if (EXT_ALU != 0) alu_d = ALUCTL_W'(ALU_EOR);
          else              known = 1'b0;
        end
        CMD_CMP: begin
          if (EXT_ALU != 0) begin
            alu_d = ALUCTL_W'(ALU_SUB); d.nowrite = 1'b1; arith = 1'b1;
          end else known = 1'b0;
        end
        CMD_CMN: begin
          if (EXT_ALU != 0) begin
            d.nowrite = 1'b1; arith = 1'b1;
          end else known = 1'b0;
        end
        CMD_TST: begin
          if (EXT_ALU != 0) begin
            alu_d = ALUCTL_W'(ALU_AND); d.nowrite = 1'b1;
          end else known = 1'b0;
        end
        default: known = 1'b0;
      endcase
      if (!known) d.regw = 1'b0;
    end
    d.flagw[1] = is_dp & funct[0];
    d.flagw[0] = is_dp & funct[0] & arith;
    // Flag-only ops never retire a register, so Rd==PC on them is not a PC write.
    d.pcs = ((rd == 4'hF) & d.regw & ~d.nowrite) | d.branch;
  end

  cond_check u_cond (
    .cond   (e.cond),
    .flags  (Flags_q[3:0]),
    .condex (condex)
  );

  assign ALUSrc_E      = e.alusrc;
  assign ALUControl_E  = alu_e;
  assign MemtoReg_E    = e.memtoreg;
  assign BranchTaken_E = e.branch & condex;
  // pcs_m is kept ungated: the hazard unit must wait until the condition has
  // been resolved into the M register before it can trust PCSrc.
  assign PCWrPending_F = d.pcs | e.pcs | pcs_m;

  always_ff @(posedge clk) begin
    if (!reset) begin
      e          <= '0;
      alu_e      <= '0;
      RegWrite_M <= 1'b0;
      MemWrite_M <= 1'b0;
      memtoreg_m <= 1'b0;
      pcsrc_m    <= 1'b0;
      pcs_m      <= 1'b0;
      RegWrite_W <= 1'b0;
      MemtoReg_W <= 1'b0;
      PCSrc_W    <= 1'b0;
      Flags_q    <= '0;
    end else begin
      if (FlushE) begin
        e     <= '0;
        alu_e <= '0;
      end else if (!StallE) begin
        e     <= d;
        alu_e <= alu_d;
      end
      if (!StallE) begin
        RegWrite_M <= e.regw & condex & ~e.nowrite;
        MemWrite_M <= e.memw & condex;
        memtoreg_m <= e.memtoreg;
        pcsrc_m    <= e.pcs & condex;
        pcs_m      <= e.pcs;
        RegWrite_W <= RegWrite_M;
        MemtoReg_W <= memtoreg_m;
        PCSrc_W    <= pcsrc_m;
        if (condex) begin
          if (e.flagw[1]) Flags_q[3:2] <= ALUFlags_E[3:2];
          if (e.flagw[0]) Flags_q[1:0] <= ALUFlags_E[1:0];
        end
      end
    end
  end

endmodule
